instr_fetch_unit: RTL

- Instruction fetch front end; naive_bus master that drives the instruction ROM's read port and feeds decode.
- Holds the PC and issues sequential word reads.
- Absorbs the ROM's one-cycle read latency in a small prefetch FIFO.
- Handles grant stalls, decode back-pressure and redirects (jump/branch/trap) from execute.

---
 rtl/instr_fetch_unit_pkg.sv | 21 ++
 rtl/instr_fetch_unit_if.sv | 32 +++
 rtl/instr_fetch_unit_fifo.sv | 74 +++++++
 rtl/instr_fetch_unit.sv | 86 ++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and constants for the instruction fetch front end
// Contents:
//   INSTR_BYTES       bytes per instruction word (PC step)
//   DEFAULT_RESET_PC  default PC loaded on reset
//   fetch_entry_t     prefetch FIFO entry {pc, instr}
//   align_pc()        clears the byte-offset bits of a fetch address
package rv_fetch_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - ROM read bus, redirect and decode handshake bundle
// Signals:
//   bus_rd_req/bus_rd_gnt/bus_rd_addr/bus_rd_data  instruction ROM read port
//   redirect_valid/redirect_pc                     restart request from execute
//   inst_valid/inst_ready/inst/inst_pc             instruction stream to decode
// Modports:
//   master  fetch unit side
//   slave   environment side (ROM, execute, decode)
interface instr_fetch_unit_if;

  logic        bus_rd_req;
  logic        bus_rd_gnt;
  logic [31:0] bus_rd_addr;
  logic [31:0] bus_rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output bus_rd_req, bus_rd_addr, inst_valid, inst, inst_pc,
    input  bus_rd_gnt, bus_rd_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  bus_rd_req, bus_rd_addr, inst_valid, inst, inst_pc,
    output bus_rd_gnt, bus_rd_data, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// rtl/instr_fetch_unit_fifo.sv - prefetch FIFO of fetch_entry_t
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data at the tail
//   push_data   entry to write
//   pop         advance the head (ignored when empty)
//   flush       empty the FIFO; wins over push in the same cycle
//   head        entry at the head (undefined when empty)
//   empty       no entries held
//   count       number of entries held (0..DEPTH)
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign w_push = push && !flush;
  assign w_pop  = pop && (r_count != '0) && !flush;

  // Storage carries no reset; the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign count = r_count;

  // The request throttle in the fetch unit guarantees a free slot for every response.
  assert property (@(posedge clk) disable iff (rst) !(w_push && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch front end feeding decode from the instruction ROM
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   instr_fetch_unit_if.master
//           ROM read port (bus_rd_*), redirect from execute, instruction stream to decode
// Parameters:
//   RESET_PC  PC loaded on reset (word aligned)
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_inflight;

  logic [CW-1:0] w_count;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic          w_pop;
  logic          w_accept;
  logic          w_room;
  logic [OW-1:0] w_occupancy;

  assign w_pop = !w_empty && bus.inst_ready;

  // Slots committed once this cycle settles: held entries plus the response on the
  // bus, minus the head decode takes now. Counting the pop keeps 1 instr/cycle.
  assign w_occupancy = OW'(w_count) + OW'(r_inflight) - OW'(w_pop);
  assign w_room      = w_occupancy < OW'(DEPTH);

  assign bus.bus_rd_req  = !rst && !bus.redirect_valid && w_room;
  assign bus.bus_rd_addr = r_pc;
  assign w_accept        = bus.bus_rd_req && bus.bus_rd_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
    end else if (bus.redirect_valid) begin
      // Any response on the bus this cycle belongs to the old stream and is dropped.
      r_pc       <= align_pc(bus.redirect_pc);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_pc     <= r_pc + 32'(INSTR_BYTES);
        r_req_pc <= r_pc;
      end
    end
  end

  assign w_push_data = '{pc: r_req_pc, instr: bus.bus_rd_data};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (bus.redirect_valid),
    .head      (w_head),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign bus.inst_valid = !w_empty;
  assign bus.inst       = w_empty ? 32'h0 : w_head.instr;
  assign bus.inst_pc    = w_empty ? 32'h0 : w_head.pc;

endmodule
